// File: rtl/l2c_mem_array.sv
// N-way set-associative tag/valid/dirty/data storage for the L2 cache behind one
// shared request port, with a post-reset sweep that clears every valid and dirty bit.
module l2c_mem_array #(
    parameter int unsigned WAY_NUM = 4,
    parameter int unsigned INDEX_W = 9,
    parameter int unsigned TAG_W   = 18,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                            clk,
    input  logic                            rst_,
    input  logic                            rw_req,
    input  logic [INDEX_W-1:0]              rw_index,
    input  logic [WAY_NUM-1:0]              wr_en_pack,
    input  logic [(DATA_W/8)*WAY_NUM-1:0]   wr_be_pack,
    input  logic [TAG_W*WAY_NUM-1:0]        wr_tag_pack,
    input  logic [WAY_NUM-1:0]              wr_valid_pack,
    input  logic [WAY_NUM-1:0]              wr_dirty_pack,
    input  logic [DATA_W*WAY_NUM-1:0]       wr_data_pack,
    output logic                            rw_rdy,
    output logic                            init_busy,
    output logic [TAG_W*WAY_NUM-1:0]        rd_tag_pack,
    output logic [WAY_NUM-1:0]              rd_valid_pack,
    output logic [WAY_NUM-1:0]              rd_dirty_pack,
    output logic [DATA_W*WAY_NUM-1:0]       rd_data_pack
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned SETS  = 2 ** INDEX_W;

    if ((DATA_W % 8) != 0 || (RD_LAT != 1 && RD_LAT != 2) || WAY_NUM < 1 || WAY_NUM > 8) begin : g_bad_param
        $error("l2c_mem_array: illegal parameter combination");
    end

    typedef enum logic [1:0] {ST_INIT, ST_READY, ST_RD1, ST_RD2} state_e;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   cnt_q, cnt_d;
    logic                 sweep_we_c, wr_go_c, rd_go_c, cap_c;

    logic [TAG_W-1:0]     tag_mem   [WAY_NUM][SETS];
    logic                 valid_mem [WAY_NUM][SETS];
    logic                 dirty_mem [WAY_NUM][SETS];
    logic [DATA_W-1:0]    data_mem  [WAY_NUM][SETS];

    logic [TAG_W*WAY_NUM-1:0]  sram_tag_q;
    logic [WAY_NUM-1:0]        sram_valid_q, sram_dirty_q;
    logic [DATA_W*WAY_NUM-1:0] sram_data_q;

    logic [TAG_W*WAY_NUM-1:0]  out_tag_q, out_tag_d;
    logic [WAY_NUM-1:0]        out_valid_q, out_valid_d, out_dirty_q, out_dirty_d;
    logic [DATA_W*WAY_NUM-1:0] out_data_q, out_data_d;

    // State and sweep counter
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + INDEX_W'(1);
                if (&cnt_q) state_d = ST_READY;
            end
            ST_READY: if (rw_req && (wr_en_pack == '0)) state_d = ST_RD1;
            ST_RD1:   state_d = (RD_LAT == 2) ? ST_RD2 : ST_READY;
            ST_RD2:   state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        rw_rdy     = 1'b0;
        init_busy  = 1'b0;
        sweep_we_c = 1'b0;
        wr_go_c    = 1'b0;
        rd_go_c    = 1'b0;
        cap_c      = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_busy  = 1'b1;
                sweep_we_c = 1'b1;
            end
            ST_READY: if (rw_req) begin
                if (|wr_en_pack) begin
                    wr_go_c = 1'b1;
                    rw_rdy  = 1'b1;
                end else begin
                    rd_go_c = 1'b1;
                end
            end
            ST_RD1: begin
                if (RD_LAT == 2) cap_c  = 1'b1;
                else             rw_rdy = 1'b1;
            end
            ST_RD2:  rw_rdy = 1'b1;
            default: init_busy = 1'b1;
        endcase
    end

    // SRAM macro model: sweep/request writes and registered read port, no reset
    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < WAY_NUM; w++) begin
            if (sweep_we_c) begin
                valid_mem[w][cnt_q] <= 1'b0;
                dirty_mem[w][cnt_q] <= 1'b0;
            end else if (wr_go_c && wr_en_pack[w]) begin
                tag_mem[w][rw_index]   <= wr_tag_pack[w*TAG_W +: TAG_W];
                valid_mem[w][rw_index] <= wr_valid_pack[w];
                dirty_mem[w][rw_index] <= wr_dirty_pack[w];
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (wr_be_pack[w*BYTES + b])
                        data_mem[w][rw_index][b*8 +: 8] <= wr_data_pack[w*DATA_W + b*8 +: 8];
                end
            end
            if (rd_go_c) begin
                sram_tag_q[w*TAG_W +: TAG_W]    <= tag_mem[w][rw_index];
                sram_valid_q[w]                 <= valid_mem[w][rw_index];
                sram_dirty_q[w]                 <= dirty_mem[w][rw_index];
                sram_data_q[w*DATA_W +: DATA_W] <= data_mem[w][rw_index];
            end
        end
    end

    // Output register, only loaded when RD_LAT=2
    always_comb begin
        out_tag_d   = out_tag_q;
        out_valid_d = out_valid_q;
        out_dirty_d = out_dirty_q;
        out_data_d  = out_data_q;
        if (cap_c) begin
            out_tag_d   = sram_tag_q;
            out_valid_d = sram_valid_q;
            out_dirty_d = sram_dirty_q;
            out_data_d  = sram_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_tag_q   <= '0;
            out_valid_q <= '0;
            out_dirty_q <= '0;
            out_data_q  <= '0;
        end else begin
            out_tag_q   <= out_tag_d;
            out_valid_q <= out_valid_d;
            out_dirty_q <= out_dirty_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_tag_pack   = (RD_LAT == 2) ? out_tag_q   : sram_tag_q;
    assign rd_valid_pack = (RD_LAT == 2) ? out_valid_q : sram_valid_q;
    assign rd_dirty_pack = (RD_LAT == 2) ? out_dirty_q : sram_dirty_q;
    assign rd_data_pack  = (RD_LAT == 2) ? out_data_q  : sram_data_q;

endmodule

// File: tb/tb_l2c_mem_array.sv
// Bench for l2c_mem_array: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=2,
// both with 4 ways, 16 sets, 18-bit tags and 64-bit lines.
module tb_l2c_mem_array;

    localparam int unsigned WN = 4;
    localparam int unsigned IW = 4;
    localparam int unsigned TW = 18;
    localparam int unsigned DW = 64;
    localparam int unsigned BY = DW / 8;
    localparam int unsigned NS = 2 ** IW;

    logic                 clk = 1'b0;
    logic                 rst_;
    logic                 req [2];
    logic [IW-1:0]        rw_index;
    logic [WN-1:0]        wr_en;
    logic [BY*WN-1:0]     wr_be;
    logic [TW*WN-1:0]     wr_tag;
    logic [WN-1:0]        wr_valid, wr_dirty;
    logic [DW*WN-1:0]     wr_data;

    logic                 rdy [2];
    logic                 busy [2];
    logic [TW*WN-1:0]     rtag [2];
    logic [WN-1:0]        rvalid [2];
    logic [WN-1:0]        rdirty [2];
    logic [DW*WN-1:0]     rdata [2];

    always #5 clk = ~clk;

    l2c_mem_array #(.WAY_NUM(WN), .INDEX_W(IW), .TAG_W(TW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_(rst_), .rw_req(req[0]), .rw_index(rw_index), .wr_en_pack(wr_en),
        .wr_be_pack(wr_be), .wr_tag_pack(wr_tag), .wr_valid_pack(wr_valid), .wr_dirty_pack(wr_dirty),
        .wr_data_pack(wr_data), .rw_rdy(rdy[0]), .init_busy(busy[0]), .rd_tag_pack(rtag[0]),
        .rd_valid_pack(rvalid[0]), .rd_dirty_pack(rdirty[0]), .rd_data_pack(rdata[0]));

    l2c_mem_array #(.WAY_NUM(WN), .INDEX_W(IW), .TAG_W(TW), .DATA_W(DW), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_(rst_), .rw_req(req[1]), .rw_index(rw_index), .wr_en_pack(wr_en),
        .wr_be_pack(wr_be), .wr_tag_pack(wr_tag), .wr_valid_pack(wr_valid), .wr_dirty_pack(wr_dirty),
        .wr_data_pack(wr_data), .rw_rdy(rdy[1]), .init_busy(busy[1]), .rd_tag_pack(rtag[1]),
        .rd_valid_pack(rvalid[1]), .rd_dirty_pack(rdirty[1]), .rd_data_pack(rdata[1]));

    // Reference contents per instance; *_k flags mark tag/bytes that have ever been written
    logic [TW-1:0] m_tag  [2][WN][NS];
    bit            m_v    [2][WN][NS];
    bit            m_d    [2][WN][NS];
    logic [DW-1:0] m_data [2][WN][NS];
    bit            m_tk   [2][WN][NS];
    bit [BY-1:0]   m_dk   [2][WN][NS];

    int checks = 0;
    int failures = 0;

    logic [TW*WN-1:0] cap_tag;
    logic [WN-1:0]    cap_valid, cap_dirty;
    logic [DW*WN-1:0] cap_data;

    typedef struct {
        bit          is_wr;
        logic [3:0]  wmask;
        logic [3:0]  idx;
        logic [17:0] tag;
        logic        v;
        logic        dty;
        logic [7:0]  dbyte;
        logic [7:0]  be;
        int          cw;
        logic [17:0] etag;
        logic        ev;
        logic        ed;
        logic [7:0]  eb0;
        logic [7:0]  ebhi;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_sweep();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < WN; w++)
                for (int i = 0; i < NS; i++) begin
                    m_v[d][w][i] = 1'b0;
                    m_d[d][w][i] = 1'b0;
                end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at a negedge with the instance idle in READY; returns at the next negedge
    task automatic do_write(input int d, input logic [3:0] m, input logic [3:0] idx,
                            input logic [TW*WN-1:0] tags, input logic [3:0] v, input logic [3:0] dty,
                            input logic [DW*WN-1:0] data, input logic [BY*WN-1:0] be);
        req[d] = 1'b1; rw_index = idx; wr_en = m; wr_tag = tags;
        wr_valid = v; wr_dirty = dty; wr_data = data; wr_be = be;
        #1;
        chk($sformatf("wr_rdy d%0d i%0d", d, idx), 256'(rdy[d]), 256'(1));
        @(negedge clk);
        for (int w = 0; w < WN; w++) begin
            if (m[w]) begin
                m_tag[d][w][idx] = tags[w*TW +: TW];
                m_tk[d][w][idx]  = 1'b1;
                m_v[d][w][idx]   = v[w];
                m_d[d][w][idx]   = dty[w];
                for (int b = 0; b < BY; b++) begin
                    if (be[w*BY + b]) begin
                        m_data[d][w][idx][b*8 +: 8] = data[w*DW + b*8 +: 8];
                        m_dk[d][w][idx][b] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic do_read(input int d, input logic [3:0] idx, input int exp_lat);
        int  lat;
        bit  got;
        logic [DW-1:0] msk;
        req[d] = 1'b1; wr_en = '0; rw_index = idx;
        #1;
        chk($sformatf("rd_rdy_req_cycle d%0d", d), 256'(rdy[d]), 256'(0));
        lat = 0; got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (rdy[d]) got = 1'b1;
        end
        chk($sformatf("rd_latency d%0d i%0d", d, idx), 256'(lat), 256'(exp_lat));
        cap_tag = rtag[d]; cap_valid = rvalid[d]; cap_dirty = rdirty[d]; cap_data = rdata[d];
        if (got) begin
            for (int w = 0; w < WN; w++) begin
                chk($sformatf("rd_valid d%0d i%0d w%0d", d, idx, w), 256'(cap_valid[w]), 256'(m_v[d][w][idx]));
                chk($sformatf("rd_dirty d%0d i%0d w%0d", d, idx, w), 256'(cap_dirty[w]), 256'(m_d[d][w][idx]));
                if (m_tk[d][w][idx])
                    chk($sformatf("rd_tag d%0d i%0d w%0d", d, idx, w), 256'(cap_tag[w*TW +: TW]), 256'(m_tag[d][w][idx]));
                for (int b = 0; b < BY; b++) msk[b*8 +: 8] = {8{m_dk[d][w][idx][b]}};
                if (msk != '0)
                    chk($sformatf("rd_data d%0d i%0d w%0d", d, idx, w),
                        256'(cap_data[w*DW +: DW] & msk), 256'(m_data[d][w][idx] & msk));
            end
        end
        req[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_sweep(input string nm);
        int  n;
        bit  bad;
        n = 0; bad = 1'b0;
        #1;
        while (busy[0] && n < 100) begin
            if (rdy[0] || rdy[1] || !busy[1]) bad = 1'b1;
            n++;
            @(negedge clk);
            #1;
        end
        chk({nm, "_busy_cycles"}, 256'(n), 256'(NS));
        chk({nm, "_rdy_during_sweep"}, 256'(bad), 256'(0));
        chk({nm, "_busy1_done"}, 256'(busy[1]), 256'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 4'b0100, 4'd5, 18'h01234, 1'b1, 1'b1, 8'hA5, 8'hFF, 0, 18'h0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 4'b0000, 4'd5, 18'h0, 1'b0, 1'b0, 8'h00, 8'h00, 2, 18'h01234, 1'b1, 1'b1, 8'hA5, 8'hA5};
        tbl[2] = '{1'b1, 4'b0100, 4'd5, 18'h01234, 1'b1, 1'b1, 8'h00, 8'h01, 0, 18'h0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[3] = '{1'b0, 4'b0000, 4'd5, 18'h0, 1'b0, 1'b0, 8'h00, 8'h00, 2, 18'h01234, 1'b1, 1'b1, 8'h00, 8'hA5};
        tbl[4] = '{1'b1, 4'b0001, 4'd7, 18'h00ABC, 1'b1, 1'b0, 8'h3C, 8'hFF, 0, 18'h0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[5] = '{1'b1, 4'b1000, 4'd7, 18'h2F00F, 1'b1, 1'b1, 8'hC3, 8'hFF, 0, 18'h0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[6] = '{1'b0, 4'b0000, 4'd7, 18'h0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 18'h00ABC, 1'b1, 1'b0, 8'h3C, 8'h3C};
        tbl[7] = '{1'b0, 4'b0000, 4'd7, 18'h0, 1'b0, 1'b0, 8'h00, 8'h00, 3, 18'h2F00F, 1'b1, 1'b1, 8'hC3, 8'hC3};

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < WN; w++)
                for (int i = 0; i < NS; i++) begin
                    m_tk[d][w][i] = 1'b0; m_dk[d][w][i] = '0;
                    m_tag[d][w][i] = '0; m_data[d][w][i] = '0;
                end
        model_sweep();

        // Reset state with a read held on both instances
        rst_ = 1'b0; req[0] = 1'b1; req[1] = 1'b1; rw_index = '0; wr_en = '0;
        wr_be = '0; wr_tag = '0; wr_valid = '0; wr_dirty = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy0", 256'(busy[0]), 256'(1));
        chk("reset_busy1", 256'(busy[1]), 256'(1));
        chk("reset_rdy0", 256'(rdy[0]), 256'(0));
        chk("reset_rdy1", 256'(rdy[1]), 256'(0));
        chk("reset_outreg_tag", 256'(rtag[1]), 256'(0));
        chk("reset_outreg_valid", 256'(rvalid[1]), 256'(0));
        chk("reset_outreg_data", 256'(rdata[1]), 256'(0));
        @(negedge clk);
        rst_ = 1'b1;
        wait_sweep("init");

        // Held read is accepted in the first READY cycle
        chk("held_req_cycle_rdy0", 256'(rdy[0]), 256'(0));
        chk("held_req_cycle_rdy1", 256'(rdy[1]), 256'(0));
        @(negedge clk); #1;
        chk("held_lat1_rdy0", 256'(rdy[0]), 256'(1));
        chk("held_lat1_rdy1", 256'(rdy[1]), 256'(0));
        chk("held_valid0", 256'(rvalid[0]), 256'(0));
        chk("held_dirty0", 256'(rdirty[0]), 256'(0));
        req[0] = 1'b0;
        @(negedge clk); #1;
        chk("held_lat2_rdy1", 256'(rdy[1]), 256'(1));
        chk("held_valid1", 256'(rvalid[1]), 256'(0));
        chk("held_dirty1", 256'(rdirty[1]), 256'(0));
        req[1] = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NS; i++) do_read(d, 4'(i), d + 1);

        // Directed table: full write, partial byte write, back-to-back multi-way
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 8; r++) begin
                if (tbl[r].is_wr) begin
                    do_write(d, tbl[r].wmask, tbl[r].idx, {WN{tbl[r].tag}}, {WN{tbl[r].v}},
                             {WN{tbl[r].dty}}, {(BY*WN){tbl[r].dbyte}}, {WN{tbl[r].be}});
                end else begin
                    do_read(d, tbl[r].idx, d + 1);
                    chk($sformatf("tbl%0d_tag d%0d", r, d), 256'(cap_tag[tbl[r].cw*TW +: TW]), 256'(tbl[r].etag));
                    chk($sformatf("tbl%0d_valid d%0d", r, d), 256'(cap_valid[tbl[r].cw]), 256'(tbl[r].ev));
                    chk($sformatf("tbl%0d_dirty d%0d", r, d), 256'(cap_dirty[tbl[r].cw]), 256'(tbl[r].ed));
                    chk($sformatf("tbl%0d_byte0 d%0d", r, d), 256'(cap_data[tbl[r].cw*DW +: 8]), 256'(tbl[r].eb0));
                    chk($sformatf("tbl%0d_byte7 d%0d", r, d), 256'(cap_data[tbl[r].cw*DW + 56 +: 8]), 256'(tbl[r].ebhi));
                end
            end
        end
        #1;
        chk("lat2_output_hold_tag", 256'(rtag[1][3*TW +: TW]), 256'(18'h2F00F));

        // Reset during RD1 of a RD_LAT=2 read
        req[1] = 1'b1; wr_en = '0; rw_index = 4'd5;
        @(negedge clk);
        #1;
        chk("midread_rd1_rdy", 256'(rdy[1]), 256'(0));
        rst_ = 1'b0;
        #1;
        chk("midread_rst_rdy", 256'(rdy[1]), 256'(0));
        chk("midread_rst_busy", 256'(busy[1]), 256'(1));
        @(negedge clk);
        #1;
        chk("midread_rst_rdy_later", 256'(rdy[1]), 256'(0));
        req[1] = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        model_sweep();
        wait_sweep("resweep");
        @(negedge clk);
        do_read(1, 4'd5, 2);
        chk("post_reset_tag_w2", 256'(cap_tag[2*TW +: TW]), 256'(18'h01234));
        chk("post_reset_valid_w2", 256'(cap_valid[2]), 256'(0));
        chk("post_reset_dirty_w2", 256'(cap_dirty[2]), 256'(0));
        do_read(0, 4'd5, 1);

        // Randomized traffic against the reference contents
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NS; i++)
                do_write(d, 4'hF, 4'(i), TW*WN'(rnd256()), 4'($urandom), 4'($urandom),
                         DW*WN'(rnd256()), '1);
            for (int n = 0; n < 120; n++) begin
                if ($urandom_range(0, 1) == 0)
                    do_write(d, 4'($urandom_range(1, 15)), 4'($urandom_range(0, NS - 1)),
                             TW*WN'(rnd256()), 4'($urandom), 4'($urandom),
                             DW*WN'(rnd256()), 32'($urandom));
                else
                    do_read(d, 4'($urandom_range(0, NS - 1)), d + 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
